// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_ME = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/hazard_if.sv
// hazard_if: pipeline-side view of the hazard controller (operands, writers, controls)
interface hazard_if #(
    parameter int REG_AW  = 6,
    parameter int NUM_SRC = 2,
    parameter int STAT_W  = 16
);
    logic [NUM_SRC*REG_AW-1:0] src_id;
    logic [NUM_SRC-1:0]        src_valid_id;
    logic                      mul_id;
    logic [NUM_SRC*REG_AW-1:0] src_ex;
    logic [NUM_SRC-1:0]        src_valid_ex;
    logic [REG_AW-1:0]         rd_ex, rd_me, rd_wb;
    logic                      we_ex, we_me, we_wb;
    logic                      load_ex, mul_start_ex, branch_taken_ex;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_if, stall_id, flush_id, flush_ex;
    logic                      mul_busy, mul_wr_en;
    logic [REG_AW-1:0]         mul_rd;
    logic [STAT_W-1:0]         stall_cnt;

    modport master (
        output src_id, src_valid_id, mul_id, src_ex, src_valid_ex,
               rd_ex, rd_me, rd_wb, we_ex, we_me, we_wb,
               load_ex, mul_start_ex, branch_taken_ex,
        input  fwd_sel, stall_if, stall_id, flush_id, flush_ex,
               mul_busy, mul_wr_en, mul_rd, stall_cnt
    );

    modport slave (
        input  src_id, src_valid_id, mul_id, src_ex, src_valid_ex,
               rd_ex, rd_me, rd_wb, we_ex, we_me, we_wb,
               load_ex, mul_start_ex, branch_taken_ex,
        output fwd_sel, stall_if, stall_id, flush_id, flush_ex,
               mul_busy, mul_wr_en, mul_rd, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one EX source operand, ME over WB
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 6,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [REG_AW-1:0] src,
    input  logic              src_valid,
    input  logic [REG_AW-1:0] rd_me,
    input  logic              we_me,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              we_wb,
    output fwd_sel_t          sel
);
    logic me_hit, wb_hit;

    // compare against both writers; the younger ME result wins
    always_comb begin
        me_hit = src_valid && we_me && src == rd_me && !(ZERO_REG_EN != 0 && rd_me == '0);
        wb_hit = src_valid && we_wb && src == rd_wb && !(ZERO_REG_EN != 0 && rd_wb == '0);
        sel    = me_hit ? FWD_ME : wb_hit ? FWD_WB : FWD_RF;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use / multiply stalls, branch flushes and stall statistics
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 6,
    parameter int NUM_SRC     = 2,
    parameter int MUL_LAT     = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int STAT_W      = 16
) (
    input logic      clk,
    input logic      rst_n,
    hazard_if.slave  bus
);
    localparam int CW = $clog2(MUL_LAT) + 1;

    mul_state_t           state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [REG_AW-1:0]    mul_rd_q;
    logic [STAT_W-1:0]    stall_cnt_q;
    logic [NUM_SRC*2-1:0] fwd_raw;
    logic                 ld_hit, mul_hit, ld_haz, mul_haz, stall, branch;

    function automatic logic hit(input logic v, input logic [REG_AW-1:0] s,
                                 input logic we, input logic [REG_AW-1:0] r);
        return v && we && s == r && !(ZERO_REG_EN != 0 && r == '0);
    endfunction

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG_EN(ZERO_REG_EN)) u_fwd (
            .src       (bus.src_ex[k*REG_AW +: REG_AW]),
            .src_valid (bus.src_valid_ex[k]),
            .rd_me     (bus.rd_me),
            .we_me     (bus.we_me),
            .rd_wb     (bus.rd_wb),
            .we_wb     (bus.we_wb),
            .sel       (fwd_raw[2*k +: 2])
        );
    end

    // ID-source hazards against the EX writer and the in-flight multiply destination
    always_comb begin
        ld_hit  = 1'b0;
        mul_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            ld_hit  = ld_hit  | hit(bus.src_valid_id[k], bus.src_id[k*REG_AW +: REG_AW], bus.we_ex, bus.rd_ex);
            mul_hit = mul_hit | hit(bus.src_valid_id[k], bus.src_id[k*REG_AW +: REG_AW], 1'b1, mul_rd_q);
        end
        ld_haz  = (bus.load_ex || bus.mul_start_ex) && ld_hit;
        mul_haz = state != IDLE && (bus.mul_id || mul_hit);
    end

    // control outputs; a taken branch overrides stalls, everything is quiet in reset
    always_comb begin
        branch        = rst_n && bus.branch_taken_ex;
        stall         = rst_n && !branch && (ld_haz || mul_haz);
        bus.stall_if  = stall;
        bus.stall_id  = stall;
        bus.flush_id  = branch;
        bus.flush_ex  = rst_n && (branch || ld_haz || mul_haz);
        bus.fwd_sel   = rst_n ? fwd_raw : '0;
        bus.mul_busy  = state != IDLE;
        bus.mul_wr_en = state == DONE;
        bus.mul_rd    = mul_rd_q;
        bus.stall_cnt = stall_cnt_q;
    end

    // multiply tracker: count down the latency, then one write-back cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: if (bus.mul_start_ex) begin
                state_nx = BUSY;
                cnt_nx   = CW'(MUL_LAT - 1);
            end
            BUSY: begin
                cnt_nx   = cnt - CW'(1);
                state_nx = cnt == CW'(1) ? DONE : BUSY;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, latched multiply destination and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mul_rd_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && bus.mul_start_ex)
                mul_rd_q <= bus.rd_ex;
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
        end
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the RSA-decryption ASIP. It replaces the combinational two-source forwarding unit, generalising register-address width and source count. It adds load-use stalls, branch flushes, and tracking of the multi-cycle modular-multiply unit through an internal FSM and latency counter. It sits beside the ID/EX/ME/WB pipeline registers and drives their forwarding muxes and stall/flush controls.

## Interface
- REG_AW, 6, register address width
- NUM_SRC, 2, source operands per instruction
- MUL_LAT, 4, modular-multiply latency in cycles (≥2)
- ZERO_REG_EN, 1, when 1 register 0 never matches (never forwarded or stalled on)
- STAT_W, 16, stall statistics counter width
---
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_id  in  NUM_SRC*REG_AW  source registers of the instruction in ID, source k at [k*REG_AW +: REG_AW]
- src_valid_id  in  NUM_SRC  per-source valid in ID
- mul_id  in  1  ID instruction is a modular-multiply
- src_ex  in  NUM_SRC*REG_AW  source registers in EX
- src_valid_ex  in  NUM_SRC  per-source valid in EX
- rd_ex, rd_me, rd_wb  in  REG_AW each  destination registers
- we_ex, we_me, we_wb  in  1 each  register-write enables
- load_ex  in  1  EX instruction is a memory load
- mul_start_ex  in  1  EX instruction issues a modular-multiply
- branch_taken_ex  in  1  branch resolved taken in EX
- fwd_sel  out  NUM_SRC*2  per-source forward select: 00 regfile, 01 WB, 10 ME
- stall_if, stall_id  out  1  hold PC and IF/ID register
- flush_id, flush_ex  out  1  bubble into ID / EX
- mul_busy  out  1  multiply unit occupied (state ≠ IDLE)
- mul_wr_en  out  1  one-cycle regfile write strobe for the multiply result
- mul_rd  out  REG_AW  latched multiply destination
- stall_cnt  out  STAT_W  saturating count of stalled cycles

## Operation
- **Match.** Source k matches register r when src_valid is set, src == r, and the writer's we is set. With ZERO_REG_EN=1, r == 0 never matches.
- **Forwarding (combinational, per source).** A match on ME gives 10. Otherwise a match on WB gives 01. Otherwise 00. ME has priority when both match.
- **Long-latency hazard (combinational).** Triggered when (load_ex or mul_start_ex) is set, we_ex is set, and any ID source matches rd_ex. Response for that cycle: stall_if=stall_id=1 and flush_ex=1.
- **FSM states.** IDLE, BUSY, DONE. Internal counter cnt is clog2(MUL_LAT)+1 bits wide.
  - IDLE → BUSY when mul_start_ex is sampled. On that edge, cnt and mul_rd load MUL_LAT-1 and rd_ex respectively.
  - BUSY: cnt decrements each cycle. BUSY → DONE when cnt == 1.
  - DONE: mul_wr_en=1 for exactly one cycle, then → IDLE.
- **Multiply hazard.** In BUSY or DONE, stall_if=stall_id=flush_ex=1 when mul_id is set or any ID source matches mul_rd.
- **Branch.** branch_taken_ex forces flush_id=flush_ex=1 and stall_if=stall_id=0, overriding every stall. An in-flight multiply continues unaffected.
- **stall_cnt.** Increments every cycle stall_id=1. It saturates at all-ones.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, cnt=0, mul_rd=0, stall_cnt=0. All outputs are 0 (fwd_sel = 00 everywhere) for the whole time rst_n is low.
- Forward, stall, and flush outputs are combinational from the current inputs and state: zero-cycle latency.
- Multiply: start sampled at edge t. BUSY covers t+1..t+MUL_LAT-1; DONE is at t+MUL_LAT. A dependent ID instruction is released at t+MUL_LAT+1.
- mul_start_ex while not IDLE cannot occur, because ID multiplies are stalled. If it is asserted anyway, it is ignored.
- Load-use stall lasts exactly one cycle; on the next cycle the load is in ME and resolved by forwarding.
- Reset asserted mid-multiply aborts immediately with no mul_wr_en pulse.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_ME=2'b10
  - mul_state_t enum: IDLE, BUSY, DONE
- Sub-module hazard_fwd_sel: single-source comparator and priority encoder, instantiated NUM_SRC times via generate. The FSM, stall logic and statistics counter stay in hazard_ctrl.

## Test plan
- Forwarding: src_ex = {6'd4, 6'd4}, rd_me=4 (we_me=1), rd_wb=4 (we_wb=1) → fwd_sel = {10,10}. Change rd_me to 3 → {01,01}. Repeat with register 0 → {00,00}.
- Load-use: load_ex=1, we_ex=1, rd_ex=5, src_id[0]=5 → stall_if=stall_id=flush_ex=1 for one cycle, stall_cnt=1.
- Multiply with MUL_LAT=4: mul_start_ex at t with rd_ex=9, then src_id[1]=9 → stalls during t+1..t+4, mul_wr_en high only at t+4 with mul_rd=9, stall released at t+5.
- Branch priority: branch_taken_ex=1 together with a load-use match → flush_id=flush_ex=1, stall_if=stall_id=0.
- Reset mid-multiply: drop rst_n in BUSY → mul_busy=0 and mul_wr_en=0 immediately. After release the FSM is IDLE and stall_cnt=0.
- Saturation: STAT_W=4 with 20 stalled cycles → stall_cnt holds at 15.
